// File: rtl/branch_seq_pkg.sv
// -----------------------------------------------------------------------------
// branch_seq_pkg
//   Shared definitions for the branch sequencer: address width, counter widths,
//   default timing parameters and the sequencer state encoding (also exported
//   on the o_state debug port, so the numeric values are fixed).
// -----------------------------------------------------------------------------
package branch_seq_pkg;

    localparam int unsigned ADDR_W            = 24;
    localparam int unsigned TAKEN_CNT_W       = 16;
    localparam int unsigned FILL_CNT_W        = 6;
    localparam int unsigned SETTLE_CNT_W      = 3;

    localparam int unsigned SETTLE_CYCLES_DEF = 2;
    localparam int unsigned FILL_TIMEOUT_DEF  = 63;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FALLTHRU  = 3'd1,
        S_RESOLVE   = 3'd2,
        S_FETCH     = 3'd3,
        S_WAIT_FILL = 3'd4,
        S_REDIRECT  = 3'd5,
        S_SETTLE    = 3'd6
    } seq_state_e;

endpackage

// File: rtl/seq_downcounter.sv
// -----------------------------------------------------------------------------
// seq_downcounter
//   Small loadable down-counter with a zero flag, used to time the SETTLE
//   phase of the branch sequencer. Load has priority over decrement; the
//   count saturates at zero.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (count -> 0)
//   load      load load_val this cycle
//   load_val  value to load
//   dec       decrement this cycle (ignored when count is already zero)
//   count     current count
//   zero      count == 0
// -----------------------------------------------------------------------------
module seq_downcounter
    import branch_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [SETTLE_CNT_W-1:0] load_val,
    input  logic                    dec,
    output logic [SETTLE_CNT_W-1:0] count,
    output logic                    zero
);

    localparam logic [SETTLE_CNT_W-1:0] CNT_ONE = 1;

    logic [SETTLE_CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//   Sequences a branch from issue to P-register reload. Not-taken branches
//   spend one FALLTHRU cycle. Taken branches resolve (optionally writing the
//   return address to B00), fetch the target into the instruction buffers on a
//   miss, reload P in REDIRECT, then settle for SETTLE_CYCLES before accepting
//   the next issue. A fill that never completes is abandoned after
//   FILL_TIMEOUT cycles and flagged in the sticky o_fill_err.
//
// Parameters
//   SETTLE_CYCLES  hold cycles after the P load (1..7)
//   FILL_TIMEOUT   maximum WAIT_FILL cycles before the error flag is raised
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   i_branch_issue   branch issues this cycle (only honoured in IDLE)
//   i_take_branch    branch condition, qualified by i_branch_issue
//   i_rtn_jump       return jump, qualified by i_branch_issue
//   i_nxt_p          branch target parcel address
//   i_ret_p          return address written to B00
//   i_ibuf_hit       target already resident in the instruction buffers
//   i_fetch_ack      memory accepted the fetch request
//   i_fetch_done     buffer fill complete
//   o_issue_hold     stall instruction issue
//   o_p_load/o_p_new one-cycle P load strobe and the new P value
//   o_fetch_req/addr buffer fetch request (level) and its address
//   o_b00_we/data    one-cycle B00 write strobe and data
//   o_taken_cnt      wrapping count of taken branches
//   o_fill_err       sticky fill-timeout flag
//   o_state          current state, for debug
// -----------------------------------------------------------------------------
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned FILL_TIMEOUT  = FILL_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_branch_issue,
    input  logic                   i_take_branch,
    input  logic                   i_rtn_jump,
    input  logic [ADDR_W-1:0]      i_nxt_p,
    input  logic [ADDR_W-1:0]      i_ret_p,
    input  logic                   i_ibuf_hit,
    input  logic                   i_fetch_ack,
    input  logic                   i_fetch_done,
    output logic                   o_issue_hold,
    output logic                   o_p_load,
    output logic [ADDR_W-1:0]      o_p_new,
    output logic                   o_fetch_req,
    output logic [ADDR_W-1:0]      o_fetch_addr,
    output logic                   o_b00_we,
    output logic [ADDR_W-1:0]      o_b00_data,
    output logic [TAKEN_CNT_W-1:0] o_taken_cnt,
    output logic                   o_fill_err,
    output logic [2:0]             o_state
);

    // The settle counter is loaded with SETTLE_CYCLES-1 and SETTLE exits on
    // the cycle it reads zero, giving exactly SETTLE_CYCLES SETTLE cycles.
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [FILL_CNT_W-1:0]   FILL_LIMIT  = FILL_CNT_W'(FILL_TIMEOUT);
    localparam logic [FILL_CNT_W-1:0]   FILL_ONE    = 1;
    localparam logic [TAKEN_CNT_W-1:0]  TAKEN_ONE   = 1;

    seq_state_e                state_q, state_d;
    logic [ADDR_W-1:0]         target_q;
    logic [ADDR_W-1:0]         ret_q;
    logic                      rtn_q;
    logic [FILL_CNT_W-1:0]     fill_cnt_q, fill_cnt_d, fill_cnt_inc;
    logic                      fill_err_q;
    logic [TAKEN_CNT_W-1:0]    taken_cnt_q;

    logic                      latch_en;
    logic                      fill_err_set;
    logic                      settle_load;
    logic                      settle_dec;
    logic                      settle_zero;
    logic [SETTLE_CNT_W-1:0]   settle_count;

    assign fill_cnt_inc = fill_cnt_q + FILL_ONE;

    seq_downcounter u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .dec      (settle_dec),
        .count    (settle_count),
        .zero     (settle_zero)
    );

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            ret_q       <= '0;
            rtn_q       <= 1'b0;
            fill_cnt_q  <= '0;
            fill_err_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            if (latch_en) begin
                target_q <= i_nxt_p;
                ret_q    <= i_ret_p;
                rtn_q    <= i_rtn_jump;
            end
            if (fill_err_set) begin
                fill_err_q <= 1'b1;
            end
            if (state_q == S_REDIRECT) begin
                taken_cnt_q <= taken_cnt_q + TAKEN_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        latch_en     = 1'b0;
        fill_cnt_d   = '0;
        fill_err_set = 1'b0;
        settle_load  = 1'b0;
        settle_dec   = 1'b0;
        o_p_load     = 1'b0;
        o_fetch_req  = 1'b0;
        o_b00_we     = 1'b0;
        // Issue is stalled combinationally in the accepting IDLE cycle, but
        // never while reset is held.
        o_issue_hold = (state_q != S_IDLE) || (i_branch_issue && !rst);

        unique case (state_q)
            S_IDLE: begin
                if (i_branch_issue) begin
                    latch_en = 1'b1;
                    state_d  = i_take_branch ? S_RESOLVE : S_FALLTHRU;
                end
            end
            S_FALLTHRU: begin
                state_d = S_IDLE;
            end
            S_RESOLVE: begin
                o_b00_we = rtn_q;
                state_d  = i_ibuf_hit ? S_REDIRECT : S_FETCH;
            end
            S_FETCH: begin
                // i_fetch_done is deliberately not looked at here, even in the
                // ack cycle; the fill counter is held at zero for WAIT_FILL.
                o_fetch_req = 1'b1;
                if (i_fetch_ack) begin
                    state_d = S_WAIT_FILL;
                end
            end
            S_WAIT_FILL: begin
                if (i_fetch_done) begin
                    state_d = S_REDIRECT;
                end else if (fill_cnt_inc == FILL_LIMIT) begin
                    fill_err_set = 1'b1;
                    state_d      = S_REDIRECT;
                end else begin
                    fill_cnt_d = fill_cnt_inc;
                end
            end
            S_REDIRECT: begin
                o_p_load    = 1'b1;
                settle_load = 1'b1;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_zero) begin
                    state_d = S_IDLE;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_p_new      = target_q;
    assign o_fetch_addr = target_q;
    assign o_b00_data   = ret_q;
    assign o_taken_cnt  = taken_cnt_q;
    assign o_fill_err   = fill_err_q;
    assign o_state      = state_q;

endmodule
